// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 6502 bus responder: address regions,
// sequencer states and the region decoder.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    RegionRam,
    RegionExt,
    RegionOpen
  } region_e;

  typedef enum logic {
    StRun,
    StWait
  } state_e;

  localparam logic [10:0] RAM_MASK = 11'h7FF;
  localparam logic [15:0] EXT_BASE = 16'h8000;

  // $0000-$1FFF work RAM, $8000-$FFFF PRG, everything else open bus.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    if (addr[15:13] == 3'b000) begin
      r = RegionRam;
    end else if (addr >= EXT_BASE) begin
      r = RegionExt;
    end else begin
      r = RegionOpen;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side and external-memory-side bus signals of the responder.
// The slave modport is the responder, the master modport is CPU core plus PRG arbiter.
interface cpu_bus_responder_if;

  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mr;
  logic        cpu_mw;
  logic        cpu_ce;
  logic [7:0]  cpu_din;
  logic        ext_req;
  logic        ext_we;
  logic [14:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;

  modport slave (
    input  cpu_aout, cpu_dout, cpu_mr, cpu_mw, ext_ack, ext_rdata,
    output cpu_ce, cpu_din, ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output cpu_aout, cpu_dout, cpu_mr, cpu_mw, ext_ack, ext_rdata,
    input  cpu_ce, cpu_din, ext_req, ext_we, ext_addr, ext_wdata
  );

endinterface

// File: rtl/nes_ram_2k.sv
// 2048x8 single-port work RAM: synchronous write, one-clock registered read.
module nes_ram_2k (
  input  logic        clk,
  input  logic        en,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata
);

  logic [7:0] mem_q [2048];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// 6502 bus responder: generates cpu_ce, decodes RAM/PRG/open bus and stretches slow PRG cycles.
// Define CPU_BUS_TIMEOUT_EN to bound external waits to TIMEOUT clocks and expose bus_err.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned CE_DIV  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
`ifdef CPU_BUS_TIMEOUT_EN
  output logic bus_err,
`endif
  cpu_bus_responder_if.slave bus
);

  localparam logic [3:0] PhaseLast = 4'(CE_DIV - 1);

  state_e      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic        start_q;
  logic        req_q, req_d;
  logic        we_q;
  logic [14:0] addr_q;
  logic [7:0]  wdata_q;
  region_e     region_q;
  logic        wr_q;
  logic [7:0]  din_q, din_d;
  logic [7:0]  ram_rdata;
  region_e     region;
  logic        start_ext;
  logic        ram_en, ram_we;
  logic        ack;
  logic        ce;
  logic        abort;
  logic        unused_mr;

  // start_q marks phase 0 of a real CPU cycle, i.e. the clock after cpu_ce.
  assign region    = decode_region(bus.cpu_aout);
  assign start_ext = start_q && (region == RegionExt);
  assign ram_en    = start_q && (region == RegionRam);
  assign ram_we    = ram_en && bus.cpu_mw;
  assign ack       = req_q && bus.ext_ack;
  assign unused_mr = bus.cpu_mr;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          bus_err_q;

  assign abort   = (state_q == StWait) && !ack && (wait_cnt_q == TW'(TIMEOUT - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
      if (abort) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = TIMEOUT;
`endif

  nes_ram_2k u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (bus.cpu_aout[10:0] & RAM_MASK),
    .wdata (bus.cpu_dout),
    .rdata (ram_rdata)
  );

  // Sequencer: a pending PRG request at the last phase freezes the phase counter.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ce      = 1'b0;
    case (state_q)
      StRun: begin
        if (phase_q == PhaseLast) begin
          if (!req_q) begin
            ce      = 1'b1;
            phase_d = '0;
          end else if (!ack) begin
            state_d = StWait;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      StWait: begin
        if (ack || abort || !req_q) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (start_ext) begin
      req_d = 1'b1;
    end else if (ack || abort) begin
      req_d = 1'b0;
    end
  end

  // cpu_din doubles as the open-bus latch; it is never written on the cpu_ce clock.
  always_comb begin
    din_d = din_q;
    if (start_q && bus.cpu_mw) begin
      din_d = bus.cpu_dout;
    end else if ((state_q == StRun) && (phase_q == 4'd1) && (region_q == RegionRam) && !wr_q) begin
      din_d = ram_rdata;
    end else if (ack && !we_q) begin
      din_d = bus.ext_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      phase_q  <= '0;
      start_q  <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      region_q <= RegionOpen;
      wr_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= ce;
      req_q   <= req_d;
      din_q   <= din_d;
      if (start_q) begin
        region_q <= region;
        wr_q     <= bus.cpu_mw;
      end
      if (start_ext) begin
        we_q    <= bus.cpu_mw;
        addr_q  <= bus.cpu_aout[14:0];
        wdata_q <= bus.cpu_dout;
      end
    end
  end

  // Request fields are visible combinationally in phase 0, then held from registers.
  assign bus.cpu_ce    = ce;
  assign bus.cpu_din   = din_q;
  assign bus.ext_req   = req_q | start_ext;
  assign bus.ext_we    = start_ext ? bus.cpu_mw : we_q;
  assign bus.ext_addr  = start_ext ? bus.cpu_aout[14:0] : addr_q;
  assign bus.ext_wdata = start_ext ? bus.cpu_dout : wdata_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder (CE_DIV = 4); timeout case runs with CPU_BUS_TIMEOUT_EN.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  logic reset_n;
`ifdef CPU_BUS_TIMEOUT_EN
  logic bus_err;
`endif

  cpu_bus_responder_if bus ();

  cpu_bus_responder #(
    .CE_DIV  (4),
    .TIMEOUT (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CPU_BUS_TIMEOUT_EN
    .bus_err (bus_err),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc_len;
  logic [7:0]  din_ce;
  logic [31:0] req_mask;
  logic [31:0] ce_mask;
  logic        we0;
  logic [14:0] addr0;
  logic [7:0]  wd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From clock 0 of a cycle, run until cpu_ce (bounded); ack_k < 0 means no ack.
  task automatic wait_ce(input int ack_k, input logic [7:0] rd);
    cyc_len  = 0;
    req_mask = '0;
    ce_mask  = '0;
    for (int c = 0; c < 200; c++) begin
      bus.ext_ack   = (c == ack_k) ? 1'b1 : 1'b0;
      bus.ext_rdata = rd;
      #1;
      if (c == 0) begin
        we0   = bus.ext_we;
        addr0 = bus.ext_addr;
        wd0   = bus.ext_wdata;
      end
      if (c < 32) begin
        req_mask[c] = bus.ext_req;
        ce_mask[c]  = bus.cpu_ce;
      end
      if (bus.cpu_ce === 1'b1) begin
        cyc_len = c + 1;
        din_ce  = bus.cpu_din;
        break;
      end
      tick();
    end
    bus.ext_ack = 1'b0;
  endtask

  // Called in a cpu_ce clock: present the next access, then follow it to its cpu_ce.
  task automatic run_cycle(input logic [15:0] addr, input logic wr, input logic [7:0] wd,
                           input int ack_k, input logic [7:0] rd);
    bus.cpu_aout = addr;
    bus.cpu_dout = wd;
    bus.cpu_mw   = wr;
    bus.cpu_mr   = !wr;
    tick();
    wait_ce(ack_k, rd);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cpu_aout  = 16'h0000;
    bus.cpu_dout  = 8'h00;
    bus.cpu_mr    = 1'b1;
    bus.cpu_mw    = 1'b0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 8'h00;
    #1;
    check("rst_cpu_ce", 32'(bus.cpu_ce), 32'h0);
    check("rst_cpu_din", 32'(bus.cpu_din), 32'h0);
    check("rst_ext_req", 32'(bus.ext_req), 32'h0);
    check("rst_ext_we", 32'(bus.ext_we), 32'h0);
    check("rst_ext_addr", 32'(bus.ext_addr), 32'h0);
    check("rst_ext_wdata", 32'(bus.ext_wdata), 32'h0);
`ifdef CPU_BUS_TIMEOUT_EN
    check("rst_bus_err", 32'(bus_err), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_ce(-1, 8'h00);
    check("first_ce_len", 32'(cyc_len), 32'd4);

    // RAM write, unrelated write to reload the open-bus latch, then mirrored read.
    run_cycle(16'h0005, 1'b1, 8'h5A, -1, 8'h00);
    check("ram_wr_len", 32'(cyc_len), 32'd4);
    check("ram_wr_noreq", req_mask, 32'h0);
    run_cycle(16'h0300, 1'b1, 8'h11, -1, 8'h00);
    run_cycle(16'h1805, 1'b0, 8'h00, -1, 8'h00);
    check("ram_mirror_din", 32'(din_ce), 32'h5A);
    check("ram_rd_len", 32'(cyc_len), 32'd4);
    check("ram_rd_noreq", req_mask, 32'h0);

    // Fast PRG read: ack at k=1, no stretch.
    run_cycle(16'hC000, 1'b0, 8'h00, 1, 8'hA9);
    check("ext_k1_len", 32'(cyc_len), 32'd4);
    check("ext_k1_din", 32'(din_ce), 32'hA9);
    check("ext_k1_req", req_mask, 32'h3);

    // Slow PRG read: ack at k=9 stretches to 11 clocks.
    run_cycle(16'hFFFC, 1'b0, 8'h00, 9, 8'h4C);
    check("ext_k9_len", 32'(cyc_len), 32'd11);
    check("ext_k9_ce", ce_mask, 32'h400);
    check("ext_k9_req", req_mask, 32'h3FF);
    check("ext_k9_din", 32'(din_ce), 32'h4C);

    // Ack on the last phase still stretches by one clock; ack at k=2 does not.
    run_cycle(16'hA000, 1'b0, 8'h00, 3, 8'h12);
    check("ext_k3_len", 32'(cyc_len), 32'd5);
    run_cycle(16'hA000, 1'b0, 8'h00, 2, 8'h34);
    check("ext_k2_len", 32'(cyc_len), 32'd4);
    check("ext_k2_din", 32'(din_ce), 32'h34);

    // PRG write, then open-bus read returns the written byte.
    run_cycle(16'h8001, 1'b1, 8'h33, 2, 8'hFF);
    check("ext_wr_we", 32'(we0), 32'h1);
    check("ext_wr_addr", 32'(addr0), 32'h0001);
    check("ext_wr_wdata", 32'(wd0), 32'h33);
    check("ext_wr_len", 32'(cyc_len), 32'd4);
    run_cycle(16'h4800, 1'b0, 8'h00, -1, 8'h00);
    check("open_din", 32'(din_ce), 32'h33);
    check("open_len", 32'(cyc_len), 32'd4);
    check("open_noreq", req_mask, 32'h0);

    // Reset while waiting on PRG, then a stale ack after release.
    bus.cpu_aout = 16'hFFFC;
    bus.cpu_mw   = 1'b0;
    bus.cpu_mr   = 1'b1;
    repeat (6) tick();
    check("wait_req_high", 32'(bus.ext_req), 32'h1);
    reset_n = 1'b0;
    bus.cpu_aout = 16'h0000;
    #1;
    check("rst_async_req", 32'(bus.ext_req), 32'h0);
    check("rst_async_ce", 32'(bus.cpu_ce), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_ce(1, 8'hEE);
    check("rst_first_ce_len", 32'(cyc_len), 32'd4);
    check("rst_stale_noreq", req_mask, 32'h0);
    check("rst_stale_din", 32'(din_ce), 32'h0);

`ifdef CPU_BUS_TIMEOUT_EN
    run_cycle(16'h0010, 1'b1, 8'h77, -1, 8'h00);
    check("to_err_before", 32'(bus_err), 32'h0);
    run_cycle(16'h9000, 1'b0, 8'h00, -1, 8'h00);
    check("to_len", 32'(cyc_len), 32'd69);
    check("to_din_kept", 32'(din_ce), 32'h77);
    check("to_bus_err", 32'(bus_err), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
